// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: tracks outstanding branch predictions in program order.
// Fetch pushes predictions and execute resolves the oldest one. Every resolve
// trains the predictor. A mispredict raises a registered redirect and drops all
// younger entries.
module branch_resolve_queue #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_valid,
    input  logic [31:0]              push_pc,
    input  logic                     push_pred_taken,
    input  logic [31:0]              push_pred_target,
    output logic                     push_ready,
    input  logic                     resolve_valid,
    input  logic                     resolve_taken,
    input  logic [31:0]              resolve_target,
    input  logic                     flush,
    output logic                     update_enable,
    output logic [31:0]              update_pc,
    output logic                     update_taken,
    output logic [31:0]              update_target,
    output logic                     redirect_valid,
    output logic [31:0]              redirect_pc,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     resolve_err,
    output logic [CNT_W-1:0]         branch_count,
    output logic [CNT_W-1:0]         mispredict_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;

    // Entry storage. The payload has no reset: control state alone defines
    // which slots are valid.
    logic [31:0]      pc_mem     [DEPTH];
    logic             taken_mem  [DEPTH];
    logic [31:0]      target_mem [DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;

    logic [31:0]      head_pc;
    logic             head_taken;
    logic [31:0]      head_target;
    logic             do_resolve;
    logic             mispredict;
    logic             clear;
    logic             do_push;
    logic             do_redirect;

    // Saturating increment for the statistics counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Full test uses only the registered count. A same-cycle pop therefore
    // cannot make room for a push.
    assign push_ready = (count < CW'(DEPTH));

    // Decode this cycle's events against the oldest entry.
    always_comb begin
        head_pc     = pc_mem[head];
        head_taken  = taken_mem[head];
        head_target = target_mem[head];
        do_resolve  = resolve_valid && (count != '0);
        mispredict  = do_resolve &&
                      ((head_taken != resolve_taken) ||
                       (resolve_taken && (head_target != resolve_target)));
        // Flush and mispredict both discard everything still queued. That
        // includes a push arriving in the same cycle, which is younger.
        clear       = flush || mispredict;
        do_push     = push_valid && push_ready && !clear;
        // An external flush wins over a branch redirect.
        do_redirect = mispredict && !flush;
    end

    // Queue pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (clear) begin
            head  <= tail;
            count <= '0;
        end else begin
            if (do_resolve) head <= head + PTR_W'(1);
            if (do_push)    tail <= tail + PTR_W'(1);
            case ({do_push, do_resolve})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Write an accepted prediction at the tail slot.
    always_ff @(posedge clk) begin
        if (do_push) begin
            pc_mem[tail]     <= push_pc;
            taken_mem[tail]  <= push_pred_taken;
            target_mem[tail] <= push_pred_target;
        end
    end

    // Predictor training port. The data fields hold their values between pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            update_enable <= 1'b0;
            update_pc     <= '0;
            update_taken  <= 1'b0;
            update_target <= '0;
        end else begin
            update_enable <= do_resolve;
            if (do_resolve) begin
                update_pc     <= head_pc;
                update_taken  <= resolve_taken;
                update_target <= resolve_target;
            end
        end
    end

    // Redirect to the correct path on a mispredict. For a not-taken branch
    // the next PC is the fall-through, which wraps at the top of the address space.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            redirect_valid <= do_redirect;
            if (do_redirect)
                redirect_pc <= resolve_taken ? resolve_target : head_pc + 32'd4;
        end
    end

    // Sticky error flag and saturating statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resolve_err      <= 1'b0;
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            if (resolve_valid && (count == '0)) resolve_err <= 1'b1;
            if (do_resolve) branch_count     <= sat_inc(branch_count);
            if (mispredict) mispredict_count <= sat_inc(mispredict_count);
        end
    end

endmodule

// File: doc/branch_resolve_queue.md
# branch_resolve_queue

In-order tracker of outstanding branch predictions between fetch and execute. Fetch pushes each predicted control-flow instruction together with its prediction. Execute resolves entries in program order. The block compares each outcome against the stored prediction, drives the predictor training port (update_enable/pc/taken/target), and issues a registered redirect with queue flush on mispredict.

## Interface
- DEPTH, 8, queue entries; power of two, ≥2
- CNT_W, 16, width of saturating statistics counters
- clk  in  1  clock, rising edge
- rst_n  in  1  reset; asynchronous, active-low
- push_valid  in  1  fetch presents a predicted control-flow instruction
- push_pc  in  32  instruction PC
- push_pred_taken  in  1  prediction (1 = taken)
- push_pred_target  in  32  predicted target; don't-care when not taken
- push_ready  out  1  queue can accept; = (count < DEPTH), from registered count only
- resolve_valid  in  1  execute resolves the oldest outstanding entry
- resolve_taken  in  1  actual direction
- resolve_target  in  32  actual computed target; valid for taken and not-taken branches
- flush  in  1  external flush (exception/trap); clears queue
- update_enable  out  1  one-cycle pulse to predictor training port
- update_pc / update_taken / update_target  out  32/1/32  training data
- redirect_valid  out  1  one-cycle mispredict pulse to PC generation
- redirect_pc  out  32  correct next PC
- count  out  $clog2(DEPTH)+1  current occupancy
- resolve_err  out  1  sticky; resolve arrived with queue empty
- branch_count / mispredict_count  out  CNT_W  saturating statistics

## Operation
- Storage: circular buffer of DEPTH entries {pc, pred_taken, pred_target}. Wrap-around head/tail pointers use a registered count.
- Push accepted when push_valid && push_ready. Entry is written at tail, tail increments modulo DEPTH.
- Resolve when resolve_valid && count != 0:
  - pop head;
  - mispredict = (pred_taken != resolve_taken) || (resolve_taken && pred_target != resolve_target);
  - update_* = {head.pc, resolve_taken, resolve_target}. Every resolved branch trains the predictor, not only mispredicts.
- Mispredict: redirect_pc = resolve_taken ? resolve_target : head.pc + 32'd4, wrapping modulo 2^32. All remaining entries are discarded: count→0, head=tail.
- A push accepted in the same cycle as a mispredicting resolve is discarded, because it is younger.
- A push in the same cycle as a correct resolve is kept; count stays unchanged.
- Resolve with count == 0: no pop, no update, no redirect; resolve_err set until reset.
- flush: clears queue (count→0) and discards any same-cycle push. A same-cycle resolve is still processed for training only: update pulse yes, redirect never.
- Statistics: branch_count increments per valid resolve, mispredict_count per mispredict. Both saturate at all-ones.
- push_ready low when full. A resolve in the same cycle does not raise push_ready early.

## Timing
- update_* and redirect_* are registered and appear the cycle after the resolve edge, as one-cycle pulses.
- update_pc/taken/target and redirect_pc hold their last values when not pulsed.
- count, push_ready and statistics reflect an edge's events after that edge.
- Push→resolve minimum latency: entry pushed at edge N may be resolved in cycle N+1.
- Reset (async, any time including mid-operation): queue empty, count=0, push_ready=1, all update_*/redirect_* outputs 0, resolve_err=0, statistics 0. Outputs go to reset values immediately on rst_n low.
- No combinational path from any input to any output.

## Test plan
- Correct prediction: push pc=0x100, pred_taken=1, target=0x200; resolve taken, 0x200 -> next cycle update_enable=1, update_pc=0x100, update_taken=1, update_target=0x200, redirect_valid=0, count=0.
- Direction mispredict with younger entries: push 0x100 (not taken), 0x104, 0x108; resolve 0x100 as taken to 0x400 -> redirect_valid=1, redirect_pc=0x400, count=0. The next resolve sets resolve_err=1.
- Target mispredict and fall-through: push 0x200 pred taken→0x300, resolve taken→0x380 gives redirect_pc=0x380. Push 0xFFFFFFFC pred taken, resolve not taken gives redirect_pc=0x00000000.
- Full/wrap: push 8 entries -> push_ready=0, 9th push ignored. Push+resolve for 20 cycles -> update_pc sequence in push order across pointer wrap.
- Simultaneous events: full queue with correct resolve + push same cycle -> push rejected (push_ready=0). Count 3 with mispredicting resolve + push -> count=0. Flush + resolve -> update pulse, no redirect, count=0.
- Reset mid-operation: assert rst_n low with 5 entries and mispredict_count=2 -> all outputs 0, push_ready=1 without waiting for a clock edge.
